seq_divider: RTL and testbench

Multi-cycle restoring divider that undoes what the adder_substracter path builds up: it computes quotient and remainder by one trial subtraction per cycle. It sits beside the single-cycle ALU and serves the RISC-V DIV/DIVU/REM/REMU group. The datapath stalls on `busy` and picks up results on `done`. Corner cases follow RV32M semantics.

---
 rtl/seq_divider_if.sv | 25 ++
 rtl/seq_divider.sv | 159 +++++++++++++++
 tb/tb_seq_divider.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// Request/result bundle between the datapath and the sequential divider.
// The master side issues start + operands; the slave side returns status and results.
interface seq_divider_if #(
   parameter int unsigned NUMBER_OF_BITS = 32
) ();
   logic                      start;
   logic                      signed_op;
   logic [NUMBER_OF_BITS-1:0] dividend;
   logic [NUMBER_OF_BITS-1:0] divisor;
   logic                      busy;
   logic                      done;
   logic [NUMBER_OF_BITS-1:0] quotient;
   logic [NUMBER_OF_BITS-1:0] remainder;
   logic                      div_by_zero;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU with RV32M corner cases.
// One trial subtraction per cycle on operand magnitudes; signs are applied at FINISH.
module seq_divider #(
   parameter int unsigned NUMBER_OF_BITS = 32
) (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);
   localparam int unsigned N    = NUMBER_OF_BITS;
   localparam int unsigned CntW = $clog2(N + 1);
   localparam logic [CntW-1:0] LastIter = CntW'(N - 1);
   localparam logic [N-1:0]    MinNeg   = {1'b1, {(N - 1){1'b0}}};

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StRun    = 2'b01,
      StFinish = 2'b10
   } state_e;

   state_e          state_q, state_d;
   // dvd holds the dividend magnitude and collects quotient bits from the LSB
   logic [N-1:0]    dvd_q, dvd_d;
   logic [N-1:0]    dvs_q, dvs_d;
   // Kept partial remainder is always below the divisor, so N bits hold it;
   // the trial subtraction itself runs N+1 bits wide.
   logic [N-1:0]    rem_q, rem_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            q_neg_q, q_neg_d;
   logic            r_neg_q, r_neg_d;
   logic            div0_q, div0_d;
   logic            ovf_q, ovf_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [N-1:0]    quot_q, quot_d;
   logic [N-1:0]    rmd_q, rmd_d;
   logic            dz_q, dz_d;

   logic [N:0]      shifted;
   logic [N:0]      trial;
   logic [N-1:0]    dvd_orig;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      q_neg_d = q_neg_q;
      r_neg_d = r_neg_q;
      div0_d  = div0_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      quot_d  = quot_q;
      rmd_d   = rmd_q;
      dz_d    = dz_q;

      shifted  = {rem_q, dvd_q[N-1]};
      trial    = shifted - {1'b0, dvs_q};
      // Re-applying the dividend sign to its magnitude recovers the original value,
      // including the most-negative case, so no extra operand copy is needed.
      dvd_orig = r_neg_q ? -dvd_q : dvd_q;

      case (state_q)
         StIdle: begin
            if (bus.start) begin
               dvd_d   = (bus.signed_op && bus.dividend[N-1]) ? -bus.dividend : bus.dividend;
               dvs_d   = (bus.signed_op && bus.divisor[N-1]) ? -bus.divisor : bus.divisor;
               q_neg_d = bus.signed_op & (bus.dividend[N-1] ^ bus.divisor[N-1]);
               r_neg_d = bus.signed_op & bus.dividend[N-1];
               div0_d  = (bus.divisor == '0);
               ovf_d   = bus.signed_op && (bus.dividend == MinNeg) && (bus.divisor == '1);
               rem_d   = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (div0_q || ovf_q) begin
               state_d = StFinish;
            end else begin
               if (!trial[N]) begin
                  rem_d = trial[N-1:0];
                  dvd_d = {dvd_q[N-2:0], 1'b1};
               end else begin
                  rem_d = shifted[N-1:0];
                  dvd_d = {dvd_q[N-2:0], 1'b0};
               end
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LastIter) begin
                  state_d = StFinish;
               end
            end
         end
         StFinish: begin
            done_d  = 1'b1;
            state_d = StIdle;
            if (div0_q) begin
               quot_d = '1;
               rmd_d  = dvd_orig;
               dz_d   = 1'b1;
            end else if (ovf_q) begin
               quot_d = MinNeg;
               rmd_d  = '0;
               dz_d   = 1'b0;
            end else begin
               quot_d = q_neg_q ? -dvd_q : dvd_q;
               rmd_d  = r_neg_q ? -rem_q : rem_q;
               dz_d   = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         div0_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         quot_q  <= '0;
         rmd_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         q_neg_q <= q_neg_d;
         r_neg_q <= r_neg_d;
         div0_q  <= div0_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         quot_q  <= quot_d;
         rmd_q   <= rmd_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rmd_q;
   assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus randomized
// operands compared against a plain-arithmetic RV32M division model.
module tb_seq_divider;
   localparam int unsigned N = 32;
   localparam logic [31:0] MinNeg = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   seq_divider_if #(.NUMBER_OF_BITS(N)) bus ();

   seq_divider #(.NUMBER_OF_BITS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // RV32M reference: division by zero and signed overflow first, then truncating division
   function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output bit dz);
      int sa, sb;
      dz = 1'b0;
      if (b == 32'd0) begin
         q  = 32'hFFFF_FFFF;
         r  = a;
         dz = 1'b1;
      end else if (s && a == MinNeg && b == 32'hFFFF_FFFF) begin
         q = a;
         r = 32'd0;
      end else if (s) begin
         sa = a;
         sb = b;
         q  = sa / sb;
         r  = sa % sb;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic launch(input bit s, input logic [31:0] a, input logic [31:0] b);
      bus.signed_op = s;
      bus.dividend  = a;
      bus.divisor   = b;
      bus.start     = 1'b1;
   endtask

   // Edge 0 is the first posedge here; returns in the done cycle (#1 after that edge)
   task automatic wait_done(input int inject_at, output int lat, output bit busy_ok);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat       = -1;
      busy_ok   = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         if (!bus.busy) busy_ok = 1'b0;
         if (i == inject_at) begin
            bus.start     = 1'b1;
            bus.signed_op = ~bus.signed_op;
            bus.dividend  = $urandom;
            bus.divisor   = $urandom;
         end
         @(posedge clk);
         #1;
         if (i == inject_at) bus.start = 1'b0;
         if (bus.done) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout: done not seen within 60 edges");
      end
   endtask

   task automatic test_reset();
      bus.start     = 1'b0;
      bus.signed_op = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      #1 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
         n_errors++;
         $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b, expected all zero",
                  bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_unsigned();
      int lat;
      bit bok;
      launch(1'b0, 32'd100, 32'd7);
      wait_done(0, lat, bok);
      n_checks += 6;
      if (lat !== 33) begin
         n_errors++; $display("FAIL unsigned_latency: got %0d expected 33", lat);
      end
      if (bus.quotient !== 32'd14) begin
         n_errors++; $display("FAIL unsigned_q: got %0d expected 14", bus.quotient);
      end
      if (bus.remainder !== 32'd2) begin
         n_errors++; $display("FAIL unsigned_r: got %0d expected 2", bus.remainder);
      end
      if (bus.div_by_zero !== 1'b0) begin
         n_errors++; $display("FAIL unsigned_dz: got %b expected 0", bus.div_by_zero);
      end
      if (bok !== 1'b1) begin
         n_errors++; $display("FAIL unsigned_busy: busy dropped before done, expected high");
      end
      if (bus.busy !== 1'b0) begin
         n_errors++; $display("FAIL unsigned_busy_done: got %b expected 0", bus.busy);
      end
      @(posedge clk);
      #1;
      n_checks += 2;
      if (bus.done !== 1'b0) begin
         n_errors++; $display("FAIL done_width: got %b expected 0 one cycle later", bus.done);
      end
      if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin
         n_errors++; $display("FAIL output_hold: got q=%0d r=%0d expected 14 2",
                              bus.quotient, bus.remainder);
      end
   endtask

   task automatic test_signed_rules();
      logic [31:0] ta [3] = '{32'hFFFF_FFF9, 32'd7,          32'hFFFF_FFF9};
      logic [31:0] tb [3] = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFE};
      logic [31:0] tq [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3};
      logic [31:0] tr [3] = '{32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
      int lat;
      bit bok;
      for (int k = 0; k < 3; k++) begin
         launch(1'b1, ta[k], tb[k]);
         wait_done(0, lat, bok);
         n_checks += 3;
         if (lat !== 33) begin
            n_errors++; $display("FAIL signed_latency[%0d]: got %0d expected 33", k, lat);
         end
         if (bus.quotient !== tq[k]) begin
            n_errors++; $display("FAIL signed_q[%0d]: got %h expected %h", k, bus.quotient, tq[k]);
         end
         if (bus.remainder !== tr[k]) begin
            n_errors++; $display("FAIL signed_r[%0d]: got %h expected %h", k, bus.remainder, tr[k]);
         end
      end
   endtask

   task automatic test_div_by_zero();
      logic [31:0] da [3] = '{32'h1234_5678, 32'h1234_5678, 32'h8765_4321};
      bit          ds [3] = '{1'b0, 1'b1, 1'b1};
      int lat;
      bit bok;
      for (int k = 0; k < 3; k++) begin
         launch(ds[k], da[k], 32'd0);
         wait_done(0, lat, bok);
         n_checks += 4;
         if (lat !== 2) begin
            n_errors++; $display("FAIL div0_latency[%0d]: got %0d expected 2", k, lat);
         end
         if (bus.quotient !== 32'hFFFF_FFFF) begin
            n_errors++; $display("FAIL div0_q[%0d]: got %h expected ffffffff", k, bus.quotient);
         end
         if (bus.remainder !== da[k]) begin
            n_errors++; $display("FAIL div0_r[%0d]: got %h expected %h", k, bus.remainder, da[k]);
         end
         if (bus.div_by_zero !== 1'b1) begin
            n_errors++; $display("FAIL div0_flag[%0d]: got %b expected 1", k, bus.div_by_zero);
         end
      end
   endtask

   task automatic test_overflow();
      int lat;
      bit bok;
      launch(1'b1, MinNeg, 32'hFFFF_FFFF);
      wait_done(0, lat, bok);
      n_checks += 4;
      if (lat !== 2) begin
         n_errors++; $display("FAIL ovf_latency: got %0d expected 2", lat);
      end
      if (bus.quotient !== MinNeg) begin
         n_errors++; $display("FAIL ovf_q: got %h expected 80000000", bus.quotient);
      end
      if (bus.remainder !== 32'd0) begin
         n_errors++; $display("FAIL ovf_r: got %h expected 0", bus.remainder);
      end
      if (bus.div_by_zero !== 1'b0) begin
         n_errors++; $display("FAIL ovf_dz: got %b expected 0", bus.div_by_zero);
      end
      launch(1'b0, MinNeg, 32'hFFFF_FFFF);
      wait_done(0, lat, bok);
      n_checks += 3;
      if (lat !== 33) begin
         n_errors++; $display("FAIL ovf_unsigned_latency: got %0d expected 33", lat);
      end
      if (bus.quotient !== 32'd0) begin
         n_errors++; $display("FAIL ovf_unsigned_q: got %h expected 0", bus.quotient);
      end
      if (bus.remainder !== MinNeg) begin
         n_errors++; $display("FAIL ovf_unsigned_r: got %h expected 80000000", bus.remainder);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      bit bok;
      bit saw_done;
      launch(1'b0, 32'd1000, 32'd3);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
         n_errors++;
         $display("FAIL reset_mid_run: got busy=%b done=%b q=%h r=%h dz=%b expected all zero",
                  bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      n_checks++;
      if (saw_done !== 1'b0) begin
         n_errors++; $display("FAIL reset_discard: got activity after reset expected none");
      end
      launch(1'b0, 32'd9, 32'd3);
      wait_done(0, lat, bok);
      n_checks += 3;
      if (lat !== 33) begin
         n_errors++; $display("FAIL after_reset_latency: got %0d expected 33", lat);
      end
      if (bus.quotient !== 32'd3) begin
         n_errors++; $display("FAIL after_reset_q: got %0d expected 3", bus.quotient);
      end
      if (bus.remainder !== 32'd0) begin
         n_errors++; $display("FAIL after_reset_r: got %0d expected 0", bus.remainder);
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      bit bok;
      logic [31:0] eq, er;
      bit edz;
      ref_div(1'b1, -32'sd1000, 32'd7, eq, er, edz);
      launch(1'b1, -32'sd1000, 32'd7);
      wait_done(5, lat, bok);
      n_checks += 3;
      if (lat !== 33) begin
         n_errors++; $display("FAIL ignore_start_latency: got %0d expected 33", lat);
      end
      if (bus.quotient !== eq || bus.quotient !== 32'hFFFF_FF72) begin
         n_errors++; $display("FAIL ignore_start_q: got %h expected %h", bus.quotient, eq);
      end
      if (bus.remainder !== er || bus.remainder !== 32'hFFFF_FFFA) begin
         n_errors++; $display("FAIL ignore_start_r: got %h expected %h", bus.remainder, er);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit bok;
      logic [31:0] a, b, eq, er;
      bit edz;
      for (int k = 0; k < 2; k++) begin
         a = $urandom;
         b = $urandom_range(1, 65535);
         ref_div(k[0], a, b, eq, er, edz);
         launch(k[0], a, b);
         wait_done(0, lat, bok);
         n_checks += 3;
         if (lat !== 33) begin
            n_errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 33", k, lat);
         end
         if (bus.quotient !== eq) begin
            n_errors++; $display("FAIL b2b_q[%0d]: got %h expected %h", k, bus.quotient, eq);
         end
         if (bus.remainder !== er) begin
            n_errors++; $display("FAIL b2b_r[%0d]: got %h expected %h", k, bus.remainder, er);
         end
      end
   endtask

   task automatic test_random();
      int lat, elat;
      bit bok, s, edz;
      logic [31:0] a, b, eq, er;
      for (int k = 0; k < 40; k++) begin
         s = 1'($urandom);
         a = $urandom;
         b = $urandom;
         case ($urandom % 8)
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: begin a = MinNeg; b = 32'hFFFF_FFFF; end
            3: b = $urandom_range(1, 15);
            4: b = -$urandom_range(1, 15);
            default: ;
         endcase
         ref_div(s, a, b, eq, er, edz);
         elat = (b == 32'd0 || (s && a == MinNeg && b == 32'hFFFF_FFFF)) ? 2 : 33;
         launch(s, a, b);
         wait_done(0, lat, bok);
         n_checks += 5;
         if (lat !== elat) begin
            n_errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, lat, elat);
         end
         if (bus.quotient !== eq) begin
            n_errors++; $display("FAIL rand_q[%0d] s=%b %h/%h: got %h expected %h",
                                 k, s, a, b, bus.quotient, eq);
         end
         if (bus.remainder !== er) begin
            n_errors++; $display("FAIL rand_r[%0d] s=%b %h/%h: got %h expected %h",
                                 k, s, a, b, bus.remainder, er);
         end
         if (bus.div_by_zero !== edz) begin
            n_errors++; $display("FAIL rand_dz[%0d]: got %b expected %b", k, bus.div_by_zero, edz);
         end
         if (bok !== 1'b1) begin
            n_errors++; $display("FAIL rand_busy[%0d]: busy low before done, expected high", k);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed_rules();
      test_div_by_zero();
      test_overflow();
      test_reset_mid_run();
      test_ignore_start();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
